// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the PC, drives a single-outstanding instruction memory
// port and produces the IF/ID register. Decode redirects flush IF/ID. A fetch that is
// still in flight when a redirect arrives is squashed.
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_fetch,
    input  logic            br_true,
    input  logic            jal_take,
    input  logic            jalr_take,
    input  logic [XLEN-1:0] br_decode,
    input  logic [XLEN-1:0] jal_decode,
    input  logic [XLEN-1:0] jalr_decode,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_decode,
    output logic [XLEN-1:0] instr_decode,
    output logic            valid_decode,
    output logic            misalign_err
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_q, inflight_d;  // address of a squashed request still in flight
    logic            squash_q, squash_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] pc_dec_q, pc_dec_d;
    logic [XLEN-1:0] instr_dec_q, instr_dec_d;
    logic            valid_dec_q, valid_dec_d;
    logic            misalign_q, misalign_d;

    logic            redirect;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
    logic            fresh_rsp;

    assign redirect  = jalr_take | jal_take | br_true;
    assign fresh_rsp = (state_q == StWait) && imem_rvalid && !squash_q;

    // Redirect target selection: jalr beats jal beats branch; low bits forced to zero.
    always_comb begin
        if (jalr_take) begin
            target_raw = jalr_decode;
        end else if (jal_take) begin
            target_raw = jal_decode;
        end else begin
            target_raw = br_decode;
        end
        target = {target_raw[XLEN-1:2], 2'b00};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a redirect always lands in WAIT so no HOLD entry survives a flush.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StWait;
            StWait: if (!redirect && fresh_rsp && stall_fetch) state_d = StHold;
            StHold: if (redirect || !stall_fetch) state_d = StWait;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: while squashing, the old address stays on the bus until its response.
    always_comb begin
        imem_req  = (state_q == StWait);
        imem_addr = squash_q ? inflight_q : pc_q;
    end

    // Datapath next state: PC, squash tracking, skid buffer and IF/ID register.
    always_comb begin
        pc_d        = pc_q;
        inflight_d  = inflight_q;
        squash_d    = squash_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        pc_dec_d    = pc_dec_q;
        instr_dec_d = instr_dec_q;
        valid_dec_d = valid_dec_q;
        misalign_d  = 1'b0;
        if (redirect) begin
            pc_d        = target;
            instr_dec_d = NOP_INSTR;
            valid_dec_d = 1'b0;
            misalign_d  = |target_raw[1:0];
            if ((state_q == StWait) && !imem_rvalid) begin
                // Keep the original in-flight address if already squashing.
                squash_d = 1'b1;
                if (!squash_q) inflight_d = pc_q;
            end else begin
                squash_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StWait: begin
                    if (imem_rvalid && squash_q) begin
                        squash_d = 1'b0;
                        if (!stall_fetch) begin
                            instr_dec_d = NOP_INSTR;
                            valid_dec_d = 1'b0;
                        end
                    end else if (imem_rvalid && stall_fetch) begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata;
                        pc_d        = pc_q + XLEN'(4);
                    end else if (imem_rvalid) begin
                        pc_dec_d    = pc_q;
                        instr_dec_d = imem_rdata;
                        valid_dec_d = 1'b1;
                        pc_d        = pc_q + XLEN'(4);
                    end else if (!stall_fetch) begin
                        instr_dec_d = NOP_INSTR;
                        valid_dec_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!stall_fetch) begin
                        pc_dec_d    = buf_pc_q;
                        instr_dec_d = buf_instr_q;
                        valid_dec_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            inflight_q  <= '0;
            squash_q    <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= NOP_INSTR;
            pc_dec_q    <= '0;
            instr_dec_q <= NOP_INSTR;
            valid_dec_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            squash_q    <= squash_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            pc_dec_q    <= pc_dec_d;
            instr_dec_q <= instr_dec_d;
            valid_dec_q <= valid_dec_d;
            misalign_q  <= misalign_d;
        end
    end

    assign pc_decode    = pc_dec_q;
    assign instr_decode = instr_dec_q;
    assign valid_decode = valid_dec_q;
    assign misalign_err = misalign_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Produces the IF/ID register (pc_decode, instr_decode) consumed by decode.
- Consumes decode's redirect targets: br_decode/br_true, jal_decode, jalr_decode.
- Owns the PC and a single-outstanding request/response port to instruction memory.
- Handles stalls, flushes on redirect, and squashing of in-flight fetches.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble inserted into IF/ID (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
stall_fetch  input  1  hold IF/ID and PC (hazard stall from downstream)
br_true  input  1  conditional branch taken, target br_decode
jal_take  input  1  JAL in decode, target jal_decode
jalr_take  input  1  JALR in decode, target jalr_decode
br_decode  input  XLEN  branch target
jal_decode  input  XLEN  JAL target
jalr_decode  input  XLEN  JALR target
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address; stable while imem_req=1
imem_rvalid  input  1  response valid; may arrive in the same cycle as the request (combinational memory) or any later cycle
imem_rdata  input  XLEN  instruction word
pc_decode  output  XLEN  IF/ID PC
instr_decode  output  XLEN  IF/ID instruction
valid_decode  output  1  IF/ID holds a real instruction
misalign_err  output  1  one-cycle pulse: redirect target had bits[1:0]!=0

Behaviour:
Reset (async, rst=1):
- pc=RESET_PC, pc_decode=0, instr_decode=NOP_INSTR, valid_decode=0.
- imem_req=0, misalign_err=0, squash=0, state=IDLE.

States:
- IDLE: one cycle after reset release, imem_req=0, then unconditionally WAIT.
- WAIT: imem_req=1, imem_addr=pc. Wait for imem_rvalid.
- HOLD: response captured in a one-entry buffer while stalled; imem_req=0.

Redirect:
- Redirect cycle = any of jalr_take, jal_take, br_true high.
- Target priority: jalr_decode > jal_decode > br_decode.
- Target bits[1:0] are forced to 0. misalign_err pulses the next cycle if the original bits were non-zero.
- Redirect beats stall_fetch. At the next edge: instr_decode=NOP_INSTR, valid_decode=0, pc=target.
  - WAIT with no rvalid this cycle: set squash, stay WAIT. imem_addr keeps the old pc until its response arrives, which is then discarded. Clear squash and issue pc=target the following cycle.
  - WAIT with rvalid this cycle: drop the response. Next cycle imem_req=1, addr=target.
  - HOLD: discard the buffer, go WAIT with addr=target.
- No redirect is registered while squash=1 unless a new redirect arrives; a new redirect overwrites the pending target.

Normal flow (no redirect):
- WAIT, rvalid, squash=0, stall_fetch=0: pc_decode<=pc, instr_decode<=imem_rdata, valid_decode<=1, pc<=pc+4. Stay WAIT, so the next request is back-to-back.
- WAIT, rvalid, stall_fetch=1: buffer {pc, rdata}, pc<=pc+4, go HOLD. IF/ID unchanged.
- HOLD, stall_fetch=0: IF/ID<=buffer, valid_decode<=1, go WAIT.
- HOLD, stall_fetch=1: stay HOLD.
- WAIT, no rvalid, stall_fetch=0: IF/ID<=NOP_INSTR, valid_decode<=0 (bubble).
- WAIT, no rvalid, stall_fetch=1: IF/ID holds.

Other rules:
- imem_rvalid outside WAIT is ignored.
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- Throughput: 1 instr/cycle with zero-latency memory; with N-cycle latency, N bubbles per instruction.
- Reset mid-WAIT: all state cleared asynchronously. A late rvalid while in IDLE is ignored.

Test Plan:
1. Reset/boot: assert rst, release. Outputs = reset values. imem_req rises one cycle after release with addr 0. Zero-latency memory returning addr as data -> pc_decode/instr_decode = 0/0, 4/4, 8/8 on consecutive cycles, valid_decode=1.
2. Latency: 2-cycle memory response from RESET_PC=0x100 -> valid_decode pattern 0,0,1 repeating. pc_decode sequence 0x100, 0x104. No duplicated or skipped PCs.
3. Stall: stall_fetch=1 for 3 cycles while a response arrives -> IF/ID frozen, imem_req=0 during HOLD. On release the buffered 0x108 instruction appears, then fetch resumes at 0x10C.
4. Squash: br_true=1, br_decode=0x200 while WAIT is pending for 0x110 (response 3 cycles later) -> next edge valid_decode=0. The 0x110 response is discarded and is never visible on instr_decode. The next imem_addr is 0x200, and pc_decode=0x200 eventually.
5. Priority/misalign: jalr_take=jal_take=br_true=1 with jalr_decode=0x303, jal=0x400, br=0x500 -> next fetch at 0x300, misalign_err pulses for 1 cycle. The same redirect coincides with rvalid and stall_fetch=1 -> flush wins and no HOLD entry is made.
6. Wrap/reset: RESET_PC=0xFFFF_FFFC -> second fetch at 0x0. Assert rst mid-WAIT with rvalid arriving during reset -> response ignored, restart at RESET_PC.
